// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  // Largest value representable in `digits` decimal digits.
  function automatic logic [31:0] max_decimal(input int digits);
    logic [31:0] m;
    m = 32'd1;
    for (int i = 0; i < digits; i++) m = m * 32'd10;
    return m - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional BIN_TO_BCD_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAXV = max_decimal(DIGITS);

  state_t               state, state_nx;
  logic [BIN_WIDTH-1:0] sreg;
  logic [AW-1:0]        acc, adj, acc_sh, result;
  logic [CW-1:0]        cnt;
  logic [31:0]          bin_ext;
  logic                 ovf_pend, spill, last, accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The bit leaving the accumulator top can only be set when the input was
  // already out of range, so folding it into ovf_pend changes nothing.
  assign {spill, acc_sh} = {adj, sreg[BIN_WIDTH-1]};
  assign last   = (cnt == CW'(BIN_WIDTH - 1));
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    bin_ext = '0;
    bin_ext[BIN_WIDTH-1:0] = bin;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
`ifdef BIN_TO_BCD_BLANK_EN
    logic seen;
    seen = 1'b0;
`endif
    result = acc_sh;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen && acc_sh[4*i +: 4] == 4'd0) result[4*i +: 4] = BCD_BLANK;
      else seen = 1'b1;
    end
`endif
    if (ovf_pend) result = {DIGITS{BCD_NINE}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      sreg     <= bin;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= (bin_ext > MAXV);
    end else if (state == SHIFT) begin
      sreg     <= sreg << 1;
      acc      <= acc_sh;
      cnt      <= cnt + CW'(1);
      ovf_pend <= ovf_pend | spill;
      if (last) begin
        bcd      <= result;
        overflow <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq (BIN_WIDTH=14, DIGITS=4).
module tb_bin_to_bcd_seq;

  logic        clk, reset_n, start;
  logic [13:0] bin;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] prev_bcd = 16'h0000;
  logic        prev_ovf = 1'b0;

  typedef struct {
    int          v;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] blank(input logic [15:0] x);
    logic [15:0] r;
    r = x;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'h0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic [15:0] model(input int v);
    if (v > 9999) return 16'h9999;
    return blank({4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)});
  endfunction

  // Called at a negedge in IDLE or DONE; inject>=0 pulses start with bin=7
  // that many cycles into SHIFT; chain leaves the bench in the DONE cycle.
  task automatic run(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                     input int inject, input bit chain, input string name);
    int k, nbusy;
    bit held;
    bin = 14'(v);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin = 14'h3FFF;
    k = 0; nbusy = 0; held = 1'b1;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      if (bcd !== prev_bcd || overflow !== prev_ovf) held = 1'b0;
      if (k == inject) begin start = 1'b1; bin = 14'd7; end
      else start = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("%s latency", name), k, 14);
    check($sformatf("%s busy_cycles", name), nbusy, 14);
    check($sformatf("%s hold", name), held, 1);
    check($sformatf("%s bcd", name), bcd, exp_bcd);
    check($sformatf("%s ovf", name), overflow, exp_ovf);
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
    if (!chain) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s done_pulse", name), done, 0);
      check($sformatf("%s idle", name), busy, 0);
    end
  endtask

  initial begin
    int ndone;
    vecs[0] = '{0,     16'h0000, 1'b0};
    vecs[1] = '{9999,  16'h9999, 1'b0};
    vecs[2] = '{12345, 16'h9999, 1'b1};
    vecs[3] = '{42,    16'h0042, 1'b0};
    vecs[4] = '{1,     16'h0001, 1'b0};
    vecs[5] = '{10000, 16'h9999, 1'b1};
    vecs[6] = '{1000,  16'h1000, 1'b0};
    vecs[7] = '{16383, 16'h9999, 1'b1};
    vecs[8] = '{5,     16'h0005, 1'b0};
    vecs[9] = '{8191,  16'h8191, 1'b0};

    reset_n = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bcd", bcd, 0);
    check("rst ovf", overflow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run(vecs[i].v, vecs[i].exp_ovf ? vecs[i].exp_bcd : blank(vecs[i].exp_bcd),
          vecs[i].exp_ovf, -1, 1'b0, $sformatf("vec%0d", i));

    // start during SHIFT ignored, then back-to-back start in DONE
    run(100, blank(16'h0100), 1'b0, 3, 1'b1, "ignore");
    run(7, blank(16'h0007), 1'b0, -1, 1'b0, "b2b");

    // reset mid-conversion
    bin = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst bcd", bcd, 0);
    check("midrst ovf", overflow, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst no_done", ndone, 0);
    prev_bcd = 16'h0000;
    prev_ovf = 1'b0;

    for (int v = 0; v < 128; v++)
      run(v, model(v), 1'b0, -1, 1'b0, $sformatf("sweep%0d", v));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
